// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// instr_fetch_stage : IF stage with IF/ID register, stall hold buffer, redirect
// Revision 1.0
// ============================================================================
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic        jump,
    input  logic [31:0] jumpTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemRdata,
    output logic        ifidValid,
    output logic [31:0] ifidInstr,
    output logic [31:0] ifidPcPlus4
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_addr, fetch_addr_nxt;
    logic [31:0] pending_pc, pending_pc_nxt;
    logic        hold_valid, hold_valid_nxt;
    logic [31:0] hold_instr, hold_instr_nxt;
    logic [31:0] hold_pc4, hold_pc4_nxt;
    logic        ifid_valid, ifid_valid_nxt;
    logic [31:0] ifid_instr, ifid_instr_nxt;
    logic [31:0] ifid_pc4, ifid_pc4_nxt;

    logic        req;
    logic        accept;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] addr_plus4;

    // While the hold buffer is full no new word may be requested.
    assign req        = ((state == ST_FETCH) && !hold_valid) || (state == ST_DRAIN);
    assign accept     = req && imemReady;
    assign redirect   = branchTaken || jump;
    assign target     = branchTaken ? branchTarget : jumpTarget;
    assign addr_plus4 = fetch_addr + 32'd4;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            fetch_addr <= RESET_PC;
            pending_pc <= RESET_PC;
            hold_valid <= 1'b0;
            hold_instr <= NOP_INSTR;
            hold_pc4   <= 32'd0;
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
            ifid_pc4   <= 32'd0;
        end else begin
            state      <= state_nxt;
            fetch_addr <= fetch_addr_nxt;
            pending_pc <= pending_pc_nxt;
            hold_valid <= hold_valid_nxt;
            hold_instr <= hold_instr_nxt;
            hold_pc4   <= hold_pc4_nxt;
            ifid_valid <= ifid_valid_nxt;
            ifid_instr <= ifid_instr_nxt;
            ifid_pc4   <= ifid_pc4_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        fetch_addr_nxt = fetch_addr;
        pending_pc_nxt = pending_pc;
        hold_valid_nxt = hold_valid;
        hold_instr_nxt = hold_instr;
        hold_pc4_nxt   = hold_pc4;
        ifid_valid_nxt = ifid_valid;
        ifid_instr_nxt = ifid_instr;
        ifid_pc4_nxt   = ifid_pc4;

        case (state)
            ST_IDLE: begin
                state_nxt = ST_FETCH;
            end

            ST_FETCH: begin
                if (redirect) begin
                    ifid_valid_nxt = 1'b0;
                    ifid_instr_nxt = NOP_INSTR;
                    hold_valid_nxt = 1'b0;
                    // An outstanding request cannot be aborted; drain it first.
                    if (req && !imemReady) begin
                        pending_pc_nxt = target;
                        state_nxt      = ST_DRAIN;
                    end else begin
                        fetch_addr_nxt = target;
                    end
                end else if (accept && !stall) begin
                    ifid_valid_nxt = 1'b1;
                    ifid_instr_nxt = imemRdata;
                    ifid_pc4_nxt   = addr_plus4;
                    fetch_addr_nxt = addr_plus4;
                end else if (accept && stall) begin
                    hold_valid_nxt = 1'b1;
                    hold_instr_nxt = imemRdata;
                    hold_pc4_nxt   = addr_plus4;
                    fetch_addr_nxt = addr_plus4;
                end else if (hold_valid && !stall) begin
                    ifid_valid_nxt = 1'b1;
                    ifid_instr_nxt = hold_instr;
                    ifid_pc4_nxt   = hold_pc4;
                    hold_valid_nxt = 1'b0;
                end else if (!stall) begin
                    ifid_valid_nxt = 1'b0;
                    ifid_instr_nxt = NOP_INSTR;
                end
            end

            ST_DRAIN: begin
                if (redirect) begin
                    pending_pc_nxt = target;
                    ifid_valid_nxt = 1'b0;
                    ifid_instr_nxt = NOP_INSTR;
                    hold_valid_nxt = 1'b0;
                end
                // Returned word belongs to the abandoned path and is dropped.
                if (imemReady) begin
                    fetch_addr_nxt = redirect ? target : pending_pc;
                    state_nxt      = ST_FETCH;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign imemReq     = req;
    assign imemAddr    = fetch_addr;
    assign ifidValid   = ifid_valid;
    assign ifidInstr   = ifid_instr;
    assign ifidPcPlus4 = ifid_pc4;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch_stage : directed self-checking bench for instr_fetch_stage
// Revision 1.0
// ============================================================================
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        jump;
    logic [31:0] jumpTarget;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemRdata;
    logic        ifidValid;
    logic [31:0] ifidInstr;
    logic [31:0] ifidPcPlus4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Memory image: word i holds i + 0x100.
    assign imemRdata = (imemAddr >> 2) + 32'h100;

    instr_fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .jump         (jump),
        .jumpTarget   (jumpTarget),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemReady    (imemReady),
        .imemRdata    (imemRdata),
        .ifidValid    (ifidValid),
        .ifidInstr    (ifidInstr),
        .ifidPcPlus4  (ifidPcPlus4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; branchTaken = 1'b0; branchTarget = 32'h0;
        jump = 1'b0; jumpTarget = 32'h0; imemReady = 1'b1;
        tick(); tick();
        total++; if (imemReq !== 1'b0) begin bad++; $display("FAIL reset_req got=%0h exp=0", imemReq); end
        total++; if (imemAddr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", imemAddr); end
        total++; if (ifidValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", ifidValid); end
        total++; if (ifidInstr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%0h exp=0", ifidInstr); end
        total++; if (ifidPcPlus4 !== 32'h0) begin bad++; $display("FAIL reset_pc4 got=%0h exp=0", ifidPcPlus4); end
        rst_n = 1'b1;
        tick();
        total++; if (imemReq !== 1'b1) begin bad++; $display("FAIL fetch_start_req got=%0h exp=1", imemReq); end
        total++; if (imemAddr !== 32'h0) begin bad++; $display("FAIL fetch_start_addr got=%0h exp=0", imemAddr); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_instr [5] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104};
        logic [31:0] exp_pc4   [5] = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (ifidValid !== 1'b1 || ifidInstr !== exp_instr[i] || ifidPcPlus4 !== exp_pc4[i]) begin
                bad++;
                $display("FAIL stream[%0d] got v=%0h i=%0h p=%0h exp v=1 i=%0h p=%0h",
                         i, ifidValid, ifidInstr, ifidPcPlus4, exp_instr[i], exp_pc4[i]);
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (ifidValid !== 1'b1 || ifidInstr !== 32'h104 || ifidPcPlus4 !== 32'h14) begin
                bad++;
                $display("FAIL stall_freeze[%0d] got i=%0h p=%0h exp i=104 p=14", i, ifidInstr, ifidPcPlus4);
            end
            total++;
            if (imemReq !== 1'b0) begin bad++; $display("FAIL stall_req[%0d] got=%0h exp=0", i, imemReq); end
        end
        stall = 1'b0;
        tick();
        total++;
        if (ifidValid !== 1'b1 || ifidInstr !== 32'h105 || ifidPcPlus4 !== 32'h18) begin
            bad++; $display("FAIL stall_release1 got v=%0h i=%0h p=%0h exp v=1 i=105 p=18", ifidValid, ifidInstr, ifidPcPlus4);
        end
        tick();
        total++;
        if (ifidValid !== 1'b1 || ifidInstr !== 32'h106 || ifidPcPlus4 !== 32'h1C) begin
            bad++; $display("FAIL stall_release2 got v=%0h i=%0h p=%0h exp v=1 i=106 p=1c", ifidValid, ifidInstr, ifidPcPlus4);
        end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1; branchTaken = 1'b1; branchTarget = 32'h40;
        tick();
        total++;
        if (ifidValid !== 1'b0 || ifidInstr !== 32'h0) begin
            bad++; $display("FAIL redir_bubble got v=%0h i=%0h exp v=0 i=0", ifidValid, ifidInstr);
        end
        total++; if (imemAddr !== 32'h40) begin bad++; $display("FAIL redir_addr got=%0h exp=40", imemAddr); end
        total++; if (imemReq !== 1'b1) begin bad++; $display("FAIL redir_req got=%0h exp=1", imemReq); end
        stall = 1'b0; branchTaken = 1'b0;
        tick();
        total++;
        if (ifidValid !== 1'b1 || ifidInstr !== 32'h110 || ifidPcPlus4 !== 32'h44) begin
            bad++; $display("FAIL redir_first got v=%0h i=%0h p=%0h exp v=1 i=110 p=44", ifidValid, ifidInstr, ifidPcPlus4);
        end
    endtask

    task automatic test_slow_jump();
        branchTaken = 1'b1; branchTarget = 32'h8;
        tick();
        branchTaken = 1'b0; imemReady = 1'b0;
        tick();
        total++;
        if (imemAddr !== 32'h8 || imemReq !== 1'b1 || ifidValid !== 1'b0) begin
            bad++; $display("FAIL slow_c1 got a=%0h r=%0h v=%0h exp a=8 r=1 v=0", imemAddr, imemReq, ifidValid);
        end
        jump = 1'b1; jumpTarget = 32'h80;
        tick();
        jump = 1'b0;
        total++;
        if (imemAddr !== 32'h8 || imemReq !== 1'b1) begin
            bad++; $display("FAIL slow_c2 got a=%0h r=%0h exp a=8 r=1", imemAddr, imemReq);
        end
        tick(); tick();
        total++;
        if (imemAddr !== 32'h8 || imemReq !== 1'b1) begin
            bad++; $display("FAIL slow_c4 got a=%0h r=%0h exp a=8 r=1", imemAddr, imemReq);
        end
        imemReady = 1'b1;
        tick();
        total++;
        if (imemAddr !== 32'h80 || ifidValid !== 1'b0) begin
            bad++; $display("FAIL slow_discard got a=%0h v=%0h exp a=80 v=0", imemAddr, ifidValid);
        end
        tick();
        total++;
        if (ifidValid !== 1'b1 || ifidInstr !== 32'h120 || ifidPcPlus4 !== 32'h84) begin
            bad++; $display("FAIL slow_first got v=%0h i=%0h p=%0h exp v=1 i=120 p=84", ifidValid, ifidInstr, ifidPcPlus4);
        end
    endtask

    task automatic test_wrap();
        branchTaken = 1'b1; branchTarget = 32'hFFFF_FFFC;
        tick();
        branchTaken = 1'b0;
        tick();
        total++;
        if (ifidValid !== 1'b1 || ifidInstr !== 32'h4000_00FF || ifidPcPlus4 !== 32'h0 || imemAddr !== 32'h0) begin
            bad++; $display("FAIL wrap got i=%0h p=%0h a=%0h exp i=400000ff p=0 a=0", ifidInstr, ifidPcPlus4, imemAddr);
        end
    endtask

    task automatic test_priority_and_reset();
        branchTaken = 1'b1; branchTarget = 32'h200; jump = 1'b1; jumpTarget = 32'h300;
        tick();
        branchTaken = 1'b0; jump = 1'b0;
        total++; if (imemAddr !== 32'h200) begin bad++; $display("FAIL prio_addr got=%0h exp=200", imemAddr); end
        tick();
        total++;
        if (ifidInstr !== 32'h180 || ifidPcPlus4 !== 32'h204) begin
            bad++; $display("FAIL prio_first got i=%0h p=%0h exp i=180 p=204", ifidInstr, ifidPcPlus4);
        end
        imemReady = 1'b0; jump = 1'b1; jumpTarget = 32'h300;
        tick();
        jump = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        total++;
        if (imemReq !== 1'b0 || imemAddr !== 32'h0 || ifidValid !== 1'b0 || ifidInstr !== 32'h0 || ifidPcPlus4 !== 32'h0) begin
            bad++; $display("FAIL drain_reset got r=%0h a=%0h v=%0h i=%0h p=%0h exp all 0",
                            imemReq, imemAddr, ifidValid, ifidInstr, ifidPcPlus4);
        end
        rst_n = 1'b1; imemReady = 1'b1;
        tick();
        total++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin bad++; $display("FAIL restart_req got r=%0h a=%0h exp r=1 a=0", imemReq, imemAddr); end
        tick();
        total++;
        if (ifidValid !== 1'b1 || ifidInstr !== 32'h100 || ifidPcPlus4 !== 32'h4) begin
            bad++; $display("FAIL restart_first got v=%0h i=%0h p=%0h exp v=1 i=100 p=4", ifidValid, ifidInstr, ifidPcPlus4);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_stall();
        test_slow_jump();
        test_wrap();
        test_priority_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
